// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;

   localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// master = upstream producer plus downstream consumer, slave = the adder.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic cell in the serial datapath.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full_adder reused every cycle.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
`ifdef SERIAL_ADDER_OVF_EN
   output logic           ovf,
`endif
   serial_adder_if.slave  bus
);

   localparam int                 CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_adder u_fa (
      .a_i  (a_q[0]),
      .b_i  (b_q[0]),
      .ci_i (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // New sum bit enters at the MSB so the LSB computed first ends up at bit 0.
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = WIDTH'({fa_s, sum_q} >> 1);
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB at this point.
               ovf_d   = carry_q ^ fa_co;
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
   logic ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf (ovf),
`endif
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present operands for one accepting edge; optionally keep in_valid high afterwards.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input bit hold_valid);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      @(posedge clk);
      #1;
      check("busy_after_accept", bus.in_ready, 1'b0);
      if (!hold_valid) bus.in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid, bounded.
   task automatic wait_done(input string tag);
      int n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, W);
   endtask

   task automatic finish_op(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      check({tag, "_idle_ready"}, bus.in_ready, 1'b1);
      check({tag, "_idle_valid"}, bus.out_valid, 1'b0);
   endtask

   task automatic add_case(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
      start_op(a, b, cin, 1'b0);
      wait_done(tag);
      check({tag, "_sum"}, bus.sum, exp_sum);
      check({tag, "_cout"}, bus.cout, exp_cout);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_sum", bus.sum, 8'h00);
      check("rst_cout", bus.cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", ovf, 1'b0);
`endif
      @(negedge clk);
      rst = 1'b0;

      add_case("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
      finish_op("basic");
      add_case("wrap1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      finish_op("wrap1");
      add_case("wrap2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      finish_op("wrap2");
      add_case("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
      finish_op("cin_only");
      add_case("wrap_cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
      finish_op("wrap_cin");

      // Backpressure: result must hold while out_ready stays low.
      add_case("bp", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", bus.out_valid, 1'b1);
         check("bp_hold_sum", bus.sum, 8'h7E);
         check("bp_hold_cout", bus.cout, 1'b0);
         check("bp_hold_in_ready", bus.in_ready, 1'b0);
      end
      finish_op("bp");

      // Busy-ignore: new operands stay valid through SHIFT and DONE.
      start_op(8'h12, 8'h34, 1'b1, 1'b1);
      bus.a   = 8'hAA;
      bus.b   = 8'h77;
      bus.cin = 1'b1;
      wait_done("busy");
      check("busy_sum", bus.sum, 8'h47);
      check("busy_cout", bus.cout, 1'b0);
      finish_op("busy");
      @(posedge clk);
      #1;
      check("busy_no_capture", bus.in_ready, 1'b1);

      // Reset after three SHIFT edges discards the operation.
      start_op(8'hF0, 8'h0F, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_in_ready", bus.in_ready, 1'b1);
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_sum", bus.sum, 8'h00);
      check("midrst_cout", bus.cout, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      check("midrst_no_result", bus.out_valid, 1'b0);
      add_case("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
      finish_op("after_rst");

`ifdef SERIAL_ADDER_OVF_EN
      add_case("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      check("ovf_pos_ovf", ovf, 1'b1);
      finish_op("ovf_pos");
      add_case("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      check("ovf_neg_ovf", ovf, 1'b1);
      finish_op("ovf_neg");
      add_case("ovf_none", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
      check("ovf_none_ovf", ovf, 1'b0);
      finish_op("ovf_none");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial multi-bit adder built around one existing full_adder instance. It processes one bit per clock, LSB first, and holds the carry in a flip-flop between bits. Operands arrive over a valid/ready input handshake, and the result leaves over a valid/ready output handshake. The block trades WIDTH cycles of latency for single-full-adder area, and feeds downstream arithmetic consumers.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set {a, b, cin} is valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
cin  input  1  carry-in for bit 0.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result a+b+cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0. The carry flop and bit counter are also 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, load the carry flop with cin, set the counter to 0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - in_ready=0; in_valid is ignored.
  - Each edge: full_adder(a_sr[0], b_sr[0], carry) produces a bit. That bit shifts into sum_sr at the MSB end, moving right. a_sr and b_sr shift right, carry takes the full_adder cout, and the counter increments.
  - On the edge where counter==WIDTH-1: go to DONE, and cout takes the final carry.
- DONE:
  - out_valid=1. sum and cout are stable until the handshake completes.
  - On an edge with out_ready=1: go to IDLE. No new operand is accepted on that same edge.
- Latency: accept on edge T; out_valid is high in the cycle after edge T+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum.
- Backpressure: out_ready may stay low indefinitely. The block holds DONE with outputs stable and in_ready=0.
- Sum visibility: sum and cout are registered outputs and only meaningful while out_valid=1. During SHIFT they may show partial values.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - {cout, sum} = a + b + cin, exactly WIDTH+1 bits.
  - Wrap case: a=all-ones, b=0, cin=1 gives sum=0, cout=1.
- Counter width: $clog2(WIDTH+1) bits, so WIDTH=1 works with one SHIFT cycle.
- Reset mid-operation: rst=1 in any state returns to the reset values on that edge. The in-flight operation is discarded and no out_valid is produced.
- rst has priority over every handshake event on the same edge.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1 bit): signed two's-complement overflow, equal to the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
  - ovf is captured on the final SHIFT edge. It is valid and stable with out_valid, and resets to 0.
- Undefined: no ovf port and no related logic; the rest of the behaviour is identical.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
  - localparam SA_DEFAULT_WIDTH = 8.
- Sub-module: the existing full_adder, instantiated once. No new sub-module is needed.
- serial_adder contains the FSM, the shift registers, the carry flop and the counter.

Test Plan:
- Basic add, WIDTH=8: a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0. out_valid rises exactly 8 edges after accept.
- Wrap-around: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Backpressure: result for a=0x3C, b=0x42 (sum=0x7E, cout=0) with out_ready held low 5 cycles → sum, cout and out_valid stable; in_ready=0 throughout. Raise out_ready → IDLE and in_ready=1 on the next cycle.
- Busy-ignore: drive in_valid=1 with new operands throughout SHIFT → they are not captured; the first result is unchanged.
- Reset mid-op: assert rst after 3 SHIFT edges → next cycle shows IDLE, in_ready=1, out_valid=0, sum=0, cout=0. A following op, a=0x01, b=0x02 → sum=0x03.
- With SERIAL_ADDER_OVF_EN:
  - a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
  - a=0x10, b=0x20 → ovf=0.
